// File: rtl/simt_mask_stack_if.sv
// Operation and read-port bundle for the per-warp SIMT divergence stack.
// The master side drives operations and selects a warp to read.
interface simt_mask_stack_if #(
    parameter int N_LANES = 8,
    parameter int DEPTH   = 8,
    parameter int N_WARPS = 4,
    parameter int PC_W    = 8
) ();
    localparam int WARP_W  = (N_WARPS > 1) ? $clog2(N_WARPS) : 1;
    localparam int DEPTH_W = $clog2(DEPTH) + 1;

    logic               op_valid;
    logic [1:0]         op_code;
    logic [WARP_W-1:0]  op_warp;
    logic [N_LANES-1:0] op_mask;
    logic [PC_W-1:0]    op_pc;
    logic [WARP_W-1:0]  rd_warp;
    logic [N_LANES-1:0] rd_mask;
    logic [PC_W-1:0]    rd_pc;
    logic [DEPTH_W-1:0] rd_depth;
    logic               rd_all_true;
    logic               rd_all_false;
    logic               err_overflow;
    logic               err_underflw;

    modport master (
        output op_valid, op_code, op_warp, op_mask, op_pc, rd_warp,
        input  rd_mask, rd_pc, rd_depth, rd_all_true, rd_all_false,
               err_overflow, err_underflw
    );

    modport slave (
        input  op_valid, op_code, op_warp, op_mask, op_pc, rd_warp,
        output rd_mask, rd_pc, rd_depth, rd_all_true, rd_all_false,
               err_overflow, err_underflw
    );
endinterface

// File: rtl/simt_mask_stack.sv
// Per-warp SIMT divergence stack: {lane mask, reconvergence PC} entries with
// push (split), complement (else path) and pop (reconverge), plus error pulses.
module simt_mask_stack #(
    parameter int N_LANES = 8,
    parameter int DEPTH   = 8,
    parameter int N_WARPS = 4,
    parameter int PC_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    simt_mask_stack_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_COMP = 2'b11
    } op_e;

    logic [N_LANES-1:0] mask_mem [N_WARPS][DEPTH];
    logic [PC_W-1:0]    pc_mem   [N_WARPS][DEPTH];
    logic [PTR_W-1:0]   ptr      [N_WARPS];

    logic [PTR_W-1:0]   cur_ptr;
    logic [IDX_W-1:0]   top_idx;
    logic [IDX_W-1:0]   up_idx;
    logic [IDX_W-1:0]   dn_idx;
    logic [N_LANES-1:0] top_mask;
    logic [N_LANES-1:0] par_mask;
    logic               is_push;
    logic               is_shrink;
    logic               do_push;
    logic               do_pop;
    logic               do_comp;
    logic               ovf;
    logic               unf;

    always_comb begin
        cur_ptr   = ptr[bus.op_warp];
        top_idx   = cur_ptr[IDX_W-1:0];
        up_idx    = top_idx + IDX_ONE;
        dn_idx    = top_idx - IDX_ONE;
        top_mask  = mask_mem[bus.op_warp][top_idx];
        par_mask  = mask_mem[bus.op_warp][dn_idx];
        is_push   = bus.op_valid && (bus.op_code == OP_PUSH);
        is_shrink = bus.op_valid && ((bus.op_code == OP_POP) || (bus.op_code == OP_COMP));
        do_push   = is_push && (cur_ptr != PTR_MAX);
        ovf       = is_push && (cur_ptr == PTR_MAX);
        do_pop    = bus.op_valid && (bus.op_code == OP_POP)  && (cur_ptr != '0);
        do_comp   = bus.op_valid && (bus.op_code == OP_COMP) && (cur_ptr != '0);
        unf       = is_shrink && (cur_ptr == '0);
    end

    // Only the base entry and the pointers matter after reset; deeper entries are
    // cleared anyway so stale divergence state never leaks across a reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < N_WARPS; w++) begin
                ptr[w] <= '0;
                for (int d = 0; d < DEPTH; d++) begin
                    mask_mem[w][d] <= (d == 0) ? '1 : '0;
                    pc_mem[w][d]   <= '0;
                end
            end
            bus.err_overflow <= 1'b0;
            bus.err_underflw <= 1'b0;
        end else begin
            bus.err_overflow <= ovf;
            bus.err_underflw <= unf;
            if (do_push) begin
                ptr[bus.op_warp]              <= cur_ptr + PTR_ONE;
                mask_mem[bus.op_warp][up_idx] <= bus.op_mask & top_mask;
                pc_mem[bus.op_warp][up_idx]   <= bus.op_pc;
            end
            if (do_pop) begin
                ptr[bus.op_warp] <= cur_ptr - PTR_ONE;
            end
            if (do_comp) begin
                mask_mem[bus.op_warp][top_idx] <= ~top_mask & par_mask;
            end
        end
    end

    logic [PTR_W-1:0] rd_ptr;
    logic [IDX_W-1:0] rd_idx;

    always_comb begin
        rd_ptr           = ptr[bus.rd_warp];
        rd_idx           = rd_ptr[IDX_W-1:0];
        bus.rd_depth     = rd_ptr;
        bus.rd_mask      = mask_mem[bus.rd_warp][rd_idx];
        bus.rd_pc        = pc_mem[bus.rd_warp][rd_idx];
        bus.rd_all_true  = &bus.rd_mask;
        bus.rd_all_false = ~|bus.rd_mask;
    end
endmodule

// File: tb/tb_simt_mask_stack.sv
// Bench for simt_mask_stack: directed vector table, overflow/underflow sequence,
// and randomized operations compared against a queue-based stack model.
module tb_simt_mask_stack;
    localparam int N_LANES = 8;
    localparam int DEPTH   = 8;
    localparam int N_WARPS = 4;
    localparam int PC_W    = 8;

    localparam logic [1:0] C_NOP  = 2'b00;
    localparam logic [1:0] C_PUSH = 2'b01;
    localparam logic [1:0] C_POP  = 2'b10;
    localparam logic [1:0] C_COMP = 2'b11;

    logic clk;
    logic reset;

    simt_mask_stack_if #(.N_LANES(N_LANES), .DEPTH(DEPTH), .N_WARPS(N_WARPS), .PC_W(PC_W)) bus ();

    simt_mask_stack #(.N_LANES(N_LANES), .DEPTH(DEPTH), .N_WARPS(N_WARPS), .PC_W(PC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] mask;
        logic [7:0] pc;
    } ent_t;

    ent_t stk [N_WARPS][$];
    logic m_ovf;
    logic m_unf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ent_t base;
        base.mask = 8'hFF;
        base.pc   = 8'h00;
        for (int w = 0; w < N_WARPS; w++) begin
            stk[w].delete();
            stk[w].push_back(base);
        end
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_apply(input logic r, input logic v, input logic [1:0] c,
                               input int w, input logic [7:0] m, input logic [7:0] p);
        ent_t e;
        int   n;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        if (r) begin
            model_reset();
        end else if (v) begin
            n = stk[w].size();
            case (c)
                C_PUSH: begin
                    if (n == DEPTH) m_ovf = 1'b1;
                    else begin
                        e.mask = m & stk[w][n-1].mask;
                        e.pc   = p;
                        stk[w].push_back(e);
                    end
                end
                C_POP: begin
                    if (n == 1) m_unf = 1'b1;
                    else void'(stk[w].pop_back());
                end
                C_COMP: begin
                    if (n == 1) m_unf = 1'b1;
                    else begin
                        e = stk[w][n-1];
                        e.mask = ~e.mask & stk[w][n-2].mask;
                        stk[w][n-1] = e;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic model_check();
        ent_t t;
        for (int w = 0; w < N_WARPS; w++) begin
            bus.rd_warp = 2'(w);
            #1;
            t = stk[w][stk[w].size()-1];
            chk($sformatf("model_mask_w%0d", w), 32'(bus.rd_mask), 32'(t.mask));
            chk($sformatf("model_pc_w%0d", w), 32'(bus.rd_pc), 32'(t.pc));
            chk($sformatf("model_depth_w%0d", w), 32'(bus.rd_depth), 32'(stk[w].size() - 1));
            chk($sformatf("model_true_w%0d", w), 32'(bus.rd_all_true), 32'(t.mask == 8'hFF));
            chk($sformatf("model_false_w%0d", w), 32'(bus.rd_all_false), 32'(t.mask == 8'h00));
        end
        chk("model_err_overflow", 32'(bus.err_overflow), 32'(m_ovf));
        chk("model_err_underflw", 32'(bus.err_underflw), 32'(m_unf));
    endtask

    // Drive at the falling edge, let the rising edge apply it, sample 1ns later.
    task automatic step(input logic r, input logic v, input logic [1:0] c,
                        input int w, input logic [7:0] m, input logic [7:0] p);
        @(negedge clk);
        reset        = r;
        bus.op_valid = v;
        bus.op_code  = c;
        bus.op_warp  = 2'(w);
        bus.op_mask  = m;
        bus.op_pc    = p;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.op_valid = 1'b0;
        model_apply(r, v, c, w, m, p);
        model_check();
    endtask

    task automatic peek(input string name, input int w, input logic [7:0] e_mask,
                        input logic [7:0] e_pc, input int e_depth);
        bus.rd_warp = 2'(w);
        #1;
        chk({name, "_mask"}, 32'(bus.rd_mask), 32'(e_mask));
        chk({name, "_pc"}, 32'(bus.rd_pc), 32'(e_pc));
        chk({name, "_depth"}, 32'(bus.rd_depth), 32'(e_depth));
    endtask

    typedef struct {
        logic       rst;
        logic       vld;
        logic [1:0] code;
        int         warp;
        logic [7:0] mask;
        logic [7:0] pc;
        int         cw;
        logic [7:0] e_mask;
        logic [7:0] e_pc;
        int         e_depth;
        logic       e_true;
        logic       e_false;
        logic       e_ovf;
        logic       e_unf;
    } vec_t;

    vec_t vecs [18];

    initial begin
        logic [7:0] pm;
        int         r;
        logic [1:0] c;

        vecs[0]  = '{1'b1, 1'b0, C_NOP,  0, 8'h00, 8'h00, 1, 8'hFF, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, C_PUSH, 1, 8'h0F, 8'h20, 1, 8'h0F, 8'h20, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, C_COMP, 1, 8'h00, 8'h00, 1, 8'hF0, 8'h20, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, C_POP,  1, 8'h00, 8'h00, 1, 8'hFF, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, C_PUSH, 1, 8'h0F, 8'h30, 1, 8'h0F, 8'h30, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, C_PUSH, 1, 8'h3C, 8'h40, 1, 8'h0C, 8'h40, 2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, C_COMP, 1, 8'h00, 8'h00, 1, 8'h03, 8'h40, 2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, C_POP,  1, 8'h00, 8'h00, 1, 8'h0F, 8'h30, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, C_POP,  1, 8'h00, 8'h00, 1, 8'hFF, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, C_PUSH, 3, 8'hF0, 8'h50, 3, 8'hF0, 8'h50, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, C_PUSH, 3, 8'h0F, 8'h60, 3, 8'h00, 8'h60, 2, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, C_POP,  3, 8'h00, 8'h00, 3, 8'hF0, 8'h50, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, C_POP,  3, 8'h00, 8'h00, 3, 8'hFF, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, C_PUSH, 2, 8'hFF, 8'h11, 2, 8'hFF, 8'h11, 1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, C_PUSH, 2, 8'hFF, 8'h12, 2, 8'hFF, 8'h12, 2, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, C_PUSH, 2, 8'hFF, 8'h13, 2, 8'hFF, 8'h13, 3, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b1, C_PUSH, 2, 8'h01, 8'h77, 2, 8'hFF, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, C_PUSH, 0, 8'h01, 8'h99, 0, 8'hFF, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0};

        reset        = 1'b1;
        bus.op_valid = 1'b0;
        bus.op_code  = C_NOP;
        bus.op_warp  = '0;
        bus.op_mask  = '0;
        bus.op_pc    = '0;
        bus.rd_warp  = '0;
        model_reset();
        repeat (2) @(posedge clk);

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].rst, vecs[i].vld, vecs[i].code, vecs[i].warp, vecs[i].mask, vecs[i].pc);
            bus.rd_warp = 2'(vecs[i].cw);
            #1;
            chk($sformatf("vec%0d_mask", i), 32'(bus.rd_mask), 32'(vecs[i].e_mask));
            chk($sformatf("vec%0d_pc", i), 32'(bus.rd_pc), 32'(vecs[i].e_pc));
            chk($sformatf("vec%0d_depth", i), 32'(bus.rd_depth), 32'(vecs[i].e_depth));
            chk($sformatf("vec%0d_true", i), 32'(bus.rd_all_true), 32'(vecs[i].e_true));
            chk($sformatf("vec%0d_false", i), 32'(bus.rd_all_false), 32'(vecs[i].e_false));
            chk($sformatf("vec%0d_ovf", i), 32'(bus.err_overflow), 32'(vecs[i].e_ovf));
            chk($sformatf("vec%0d_unf", i), 32'(bus.err_underflw), 32'(vecs[i].e_unf));
        end

        // Fill warp 0 with narrowing masks, then hit both error boundaries.
        for (int i = 1; i <= 7; i++) begin
            pm = 8'hFF >> i;
            step(1'b0, 1'b1, C_PUSH, 0, pm, 8'(i));
        end
        peek("full", 0, 8'h01, 8'h07, 7);
        step(1'b0, 1'b1, C_PUSH, 0, 8'hFF, 8'hEE);
        chk("ovf_pulse", 32'(bus.err_overflow), 32'd1);
        peek("ovf_keep", 0, 8'h01, 8'h07, 7);
        step(1'b0, 1'b1, C_NOP, 0, 8'h00, 8'h00);
        chk("ovf_clear", 32'(bus.err_overflow), 32'd0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, C_POP, 0, 8'h00, 8'h00);
        peek("emptied", 0, 8'hFF, 8'h00, 0);
        step(1'b0, 1'b1, C_POP, 0, 8'h00, 8'h00);
        chk("unf_pop", 32'(bus.err_underflw), 32'd1);
        step(1'b0, 1'b1, C_COMP, 0, 8'h00, 8'h00);
        chk("unf_comp", 32'(bus.err_underflw), 32'd1);
        peek("base_kept", 0, 8'hFF, 8'h00, 0);
        step(1'b0, 1'b0, C_COMP, 0, 8'h00, 8'h00);
        chk("unf_clear", 32'(bus.err_underflw), 32'd0);

        // Random phase: push-heavy first half, pop-heavy second half.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 9);
            if (i < 1500) c = (r == 0) ? C_NOP : (r <= 5) ? C_PUSH : (r <= 7) ? C_POP : C_COMP;
            else          c = (r == 0) ? C_NOP : (r <= 2) ? C_PUSH : (r <= 6) ? C_POP : C_COMP;
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) != 0), c,
                 $urandom_range(0, N_WARPS - 1), 8'($urandom), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
